// File: rtl/gearbox_pkg.sv
// rtl/gearbox_pkg.sv - shared types and constants for the gearbox write-port arbiter
package gearbox_pkg;
    localparam int WORD_W      = 16;
    localparam int GROUP_WORDS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAD   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/gearbox_arbiter_rr.sv
// rtl/gearbox_arbiter_rr.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);
    logic [IDW-1:0] w_cand;

    // Walk i_last+1 .. i_last+N (mod N) so the previous owner is checked last.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDW'((int'(i_last) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gearbox_arbiter.sv
// rtl/gearbox_arbiter.sv - round-robin arbiter granting whole 80-bit-aligned groups to the gearbox
module gearbox_arbiter
    import gearbox_pkg::*;
#(
    parameter int              NUM_REQ     = 2,
    parameter int              BURST_WORDS = 5,
    parameter int              TIMEOUT     = 8,
    parameter logic [WORD_W-1:0] PAD_WORD  = '0
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [WORD_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        gb_full,
    output logic                        gb_shift_in,
    output logic [WORD_W-1:0]           gb_data_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        pad_pulse
);
    localparam int GID_W = $clog2(NUM_REQ);
    localparam int WC_W  = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int SC_W  = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] LAST_WORD   = WC_W'(BURST_WORDS - 1);
    localparam logic [SC_W-1:0] STARVE_LAST = SC_W'(TIMEOUT - 1);

    if (BURST_WORDS % GROUP_WORDS != 0 || BURST_WORDS == 0) begin : g_bad_burst
        $error("BURST_WORDS must be a nonzero multiple of GROUP_WORDS");
    end

    arb_state_t        r_state;
    logic [WC_W-1:0]   r_word_cnt;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [GID_W-1:0]  r_grant;
    logic [GID_W-1:0]  r_last_grant;
    logic              r_pad_pulse;

    logic [GID_W-1:0]  w_pick;
    logic              w_any;
    logic [WORD_W-1:0] w_words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign w_words[i] = req_data[i*WORD_W +: WORD_W];
    end

    rr_arbiter #(.N(NUM_REQ), .IDW(GID_W)) u_rr (
        .i_req  (req_valid),
        .i_last (r_last_grant),
        .o_idx  (w_pick),
        .o_any  (w_any)
    );

    // Write side is purely combinational so a source word reaches the gearbox in the same cycle.
    always_comb begin
        req_ready   = '0;
        gb_shift_in = 1'b0;
        gb_data_in  = '0;
        case (r_state)
            BURST: begin
                req_ready[r_grant] = !gb_full;
                gb_shift_in        = req_valid[r_grant] & !gb_full;
                gb_data_in         = w_words[r_grant];
            end
            PAD: begin
                gb_shift_in = !gb_full;
                gb_data_in  = PAD_WORD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_starve_cnt <= '0;
            r_grant      <= '0;
            r_last_grant <= GID_W'(NUM_REQ - 1);
            r_pad_pulse  <= 1'b0;
        end else begin
            r_pad_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_pick;
                        r_word_cnt   <= '0;
                        r_starve_cnt <= '0;
                        r_state      <= BURST;
                    end
                end
                BURST: begin
                    if (gb_shift_in) begin
                        r_word_cnt   <= r_word_cnt + 1'b1;
                        r_starve_cnt <= '0;
                        if (r_word_cnt == LAST_WORD) begin
                            r_state      <= IDLE;
                            r_last_grant <= r_grant;
                        end
                    end else if (!gb_full) begin
                        // Only source silence counts toward the timeout; gearbox backpressure does not.
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                        if (r_starve_cnt == STARVE_LAST) begin
                            r_state <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (gb_shift_in) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == LAST_WORD) begin
                            r_state      <= IDLE;
                            r_last_grant <= r_grant;
                            r_pad_pulse  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_id  = r_grant;
    assign busy      = (r_state != IDLE);
    assign pad_pulse = r_pad_pulse;
endmodule

// File: tb/tb_gearbox_arbiter.sv
// tb/tb_gearbox_arbiter.sv - self-checking bench for gearbox_arbiter
module tb_gearbox_arbiter;
    localparam int          N    = 3;
    localparam int          BW   = 5;
    localparam int          TO   = 8;
    localparam logic [15:0] PADW = 16'hA5A5;

    logic            clk = 1'b0;
    logic            res = 1'b0;
    logic [N-1:0]    v = '0;
    logic [16*N-1:0] d = '0;
    logic            full = 1'b0;
    logic [N-1:0]    ready;
    logic            shift;
    logic [15:0]     gdata;
    logic [1:0]      gid;
    logic            busy;
    logic            pulse;

    gearbox_arbiter #(
        .NUM_REQ(N), .BURST_WORDS(BW), .TIMEOUT(TO), .PAD_WORD(PADW)
    ) dut (
        .clk(clk), .res(res), .req_valid(v), .req_data(d), .req_ready(ready),
        .gb_full(full), .gb_shift_in(shift), .gb_data_in(gdata),
        .grant_id(gid), .busy(busy), .pad_pulse(pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the port, how many words of the group are done, how long the owner has been silent.
    int m_owner = -1;
    int m_last = N - 1;
    int m_gid = 0;
    int m_done = 0;
    int m_starve = 0;
    bit m_pad = 1'b0;
    bit m_pulse = 1'b0;
    int sb_cnt = 0;
    bit sb_busy = 1'b0;
    bit sb_on = 1'b0;
    int sb_seq [N];

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic         e_shift;
        logic [15:0]  e_data;
        int           src;
        if (res) begin
            m_owner = -1; m_last = N - 1; m_gid = 0; m_pad = 1'b0; m_pulse = 1'b0;
            sb_cnt = 0; sb_busy = 1'b0;
        end
        e_ready = '0; e_shift = 1'b0; e_data = '0;
        if (m_owner >= 0) begin
            if (!m_pad) begin
                e_ready = full ? '0 : (N'(1) << m_owner);
                e_shift = v[m_owner] && !full;
                e_data  = d[16*m_owner +: 16];
            end else begin
                e_shift = !full;
                e_data  = PADW;
            end
        end
        cmp("m_ready", ready, e_ready);
        cmp("m_shift", shift, e_shift);
        cmp("m_data", gdata, e_data);
        cmp("m_grant", gid, m_gid);
        cmp("m_busy", busy, m_owner >= 0);
        cmp("m_pulse", pulse, m_pulse);
        if (!res) begin
            if (sb_busy && !busy) begin
                cmp("sb_group_len", sb_cnt, BW);
                sb_cnt = 0;
            end
            if (shift) sb_cnt++;
            sb_busy = busy;
            if (sb_on && shift && gdata != PADW) begin
                src = int'(gdata[15:12]);
                if (src < N) begin
                    cmp("sb_order", gdata[11:0], sb_seq[src] & 12'hFFF);
                    sb_seq[src]++;
                end else begin
                    cmp("sb_src", src, 0);
                end
            end
            m_pulse = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (m_owner < 0 && v[c]) m_owner = c;
                end
                if (m_owner >= 0) begin
                    m_gid = m_owner; m_done = 0; m_starve = 0; m_pad = 1'b0;
                end
            end else if (e_shift) begin
                m_done++;
                m_starve = 0;
                if (m_done == BW) begin
                    m_pulse = m_pad; m_last = m_owner; m_owner = -1; m_pad = 1'b0;
                end
            end else if (!m_pad && !full) begin
                m_starve++;
                if (m_starve == TO) m_pad = 1'b1;
            end
        end
    end

    int seq [N];
    logic [N-1:0] acc;

    initial begin
        #1 res = 1'b1;
        #2;
        cmp("rst_busy", busy, 0);
        cmp("rst_shift", shift, 0);
        cmp("rst_ready", ready, 0);
        cmp("rst_grant", gid, 0);
        cmp("rst_pulse", pulse, 0);
        step; step; res = 1'b0;

        // 1: single source, one clean group
        v = 3'b001; d[15:0] = 16'h1; #1;
        cmp("t1_arb_shift", shift, 0);
        cmp("t1_arb_busy", busy, 0);
        step;
        for (int k = 1; k <= 5; k++) begin
            d[15:0] = 16'(k); #1;
            cmp("t1_shift", shift, 1);
            cmp("t1_data", gdata, k);
            step;
        end
        v = '0; #1;
        cmp("t1_busy_drop", busy, 0);

        // 2: two sources always valid
        res = 1'b1; step; step; res = 1'b0;
        v = 3'b011; d = {16'h0, 16'h0B0B, 16'h0A0A}; #1;
        for (int g = 0; g < 4; g++) begin
            cmp("t2_arb_busy", busy, 0);
            step;
            cmp("t2_grant", gid, g % 2);
            for (int w = 0; w < 5; w++) begin
                cmp("t2_shift", shift, 1);
                cmp("t2_data", gdata, (g % 2) ? 16'h0B0B : 16'h0A0A);
                step;
            end
        end
        v = '0; #1;

        // 3: src1 sends two words then starves
        v = 3'b010; d[31:16] = 16'h0021; #1;
        step;
        cmp("t3_grant", gid, 1);
        cmp("t3_w0", gdata, 16'h0021);
        step;
        d[31:16] = 16'h0022; #1;
        cmp("t3_w1", gdata, 16'h0022);
        cmp("t3_w1_shift", shift, 1);
        step;
        v = '0; #1;
        for (int s = 0; s < TO; s++) begin
            cmp("t3_starve_shift", shift, 0);
            cmp("t3_starve_busy", busy, 1);
            step;
        end
        for (int p = 0; p < 3; p++) begin
            cmp("t3_pad_shift", shift, 1);
            cmp("t3_pad_data", gdata, PADW);
            cmp("t3_pad_ready", ready, 0);
            step;
        end
        cmp("t3_pulse", pulse, 1);
        cmp("t3_idle", busy, 0);
        step;
        cmp("t3_pulse_clr", pulse, 0);

        // 4: gearbox full for 20 cycles mid-burst
        v = 3'b001; d[15:0] = 16'h0041; #1;
        step;
        cmp("t4_grant", gid, 0);
        cmp("t4_w0", gdata, 16'h0041);
        step;
        d[15:0] = 16'h0042; #1;
        cmp("t4_w1", gdata, 16'h0042);
        step;
        full = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) v = '0;
            #1;
            cmp("t4_full_shift", shift, 0);
            cmp("t4_full_ready", ready, 0);
            cmp("t4_full_busy", busy, 1);
            step;
        end
        full = 1'b0; v = 3'b001;
        for (int k = 3; k <= 5; k++) begin
            d[15:0] = 16'h0040 + 16'(k); #1;
            cmp("t4_resume_shift", shift, 1);
            cmp("t4_resume_data", gdata, 16'h0040 + k);
            step;
        end
        v = '0; #1;
        cmp("t4_idle", busy, 0);
        cmp("t4_no_pad", pulse, 0);

        // 5: reset in the middle of a group
        v = 3'b011; d[15:0] = 16'h0A0A; d[31:16] = 16'h0B0B; #1;
        step;
        cmp("t5_grant", gid, 1);
        for (int w = 0; w < 3; w++) begin
            cmp("t5_pre_shift", shift, 1);
            step;
        end
        res = 1'b1; #1;
        cmp("t5_rst_ready", ready, 0);
        cmp("t5_rst_shift", shift, 0);
        cmp("t5_rst_data", gdata, 0);
        cmp("t5_rst_busy", busy, 0);
        cmp("t5_rst_grant", gid, 0);
        cmp("t5_rst_pulse", pulse, 0);
        step; res = 1'b0; #1;
        cmp("t5_arb_busy", busy, 0);
        step;
        cmp("t5_regrant", gid, 0);
        for (int w = 0; w < 5; w++) begin
            cmp("t5_shift", shift, 1);
            cmp("t5_data", gdata, 16'h0A0A);
            step;
        end
        v = '0; #1;
        cmp("t5_idle", busy, 0);

        // 6: random valid/full stress on three sources
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; sb_seq[i] = 0;
            d[16*i +: 16] = {4'(i), 12'h000};
        end
        sb_on = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = v & ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) seq[i]++;
                v[i] = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                d[16*i +: 16] = {4'(i), 12'(seq[i])};
            end
            full = ($urandom_range(0, 4) == 0);
        end
        v = '0; full = 1'b0;
        for (int c = 0; c < 40 && busy; c++) step;
        cmp("t6_drain_idle", busy, 0);
        step; step;
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
